mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The module SHALL have a single clock `clk`, and its reset is synchronous and active-low (`rst_n`).
REQ-002 Port list, one per line, as name, direction, width, meaning:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- stall  in  1  hold the current stage contents.
- flush  in  1  load a bubble into the stage.
- in_valid  in  1  the incoming MEM-stage instruction is valid.
- in_reg_write  in  1  the incoming instruction writes rd.
- in_mem_to_reg  in  1  1 selects load data; 0 selects ALU result.
- in_rd  in  5  destination register.
- in_funct3  in  3  load type.
- in_addr_lo  in  3  effective address bits [2:0].
- in_alu_result  in  64  ALU result.
- in_mem_data  in  64  raw doubleword from data memory, little-endian.
- dec_rs1, dec_rs2  in  5 each  decode-stage source indices (bypass only).
- rf_data1, rf_data2  in  64 each  register-file read data (bypass only).
- reg_write  out  1  register-file write enable.
- rd  out  5  register-file write index.
- write_data  out  64  register-file write data.
- wb_valid  out  1  a valid instruction occupies WB.
- instret  out  64  count of retired instructions.
- fwd_data1, fwd_data2  out  64 each  bypassed operands (bypass only).

Function
REQ-003 Latency SHALL be one cycle: inputs sampled on edge N appear on the outputs after edge N.
REQ-004 Load formatting SHALL be combinational ahead of the stage register, so the register holds the final write_data.
REQ-005 Load formatting by in_funct3 SHALL be:
- 000 lb: sign-extend a byte.
- 001 lh: sign-extend a half.
- 010 lw: sign-extend a word.
- 011 ld: full doubleword.
- 100 lbu: zero-extend a byte.
- 101 lhu: zero-extend a half.
- 110 lwu: zero-extend a word.
- 111: treated as ld.
REQ-006 The byte lane SHALL be in_addr_lo, aligned down to the access size (half: bit 0 ignored; word: bits [1:0] ignored); no misalignment trap is raised.
REQ-007 When in_mem_to_reg=0, write_data SHALL be in_alu_result unmodified, and in_funct3/in_addr_lo are ignored.
REQ-008 reg_write SHALL equal the latched in_reg_write AND in_valid AND (in_rd != 0); a write to x0 is never issued.
REQ-009 Priority SHALL be flush > stall > load; a flush clears wb_valid and reg_write, and rd/write_data become 0.
REQ-010 While stall=1 and flush=0, all stage outputs SHALL hold their values.
REQ-011 instret SHALL increment by 1 on each edge at which wb_valid=1 and stall=0, and it wraps from 2^64-1 to 0.
REQ-012 A simultaneous flush and a retiring instruction SHALL still count the retiring instruction.

Reset
REQ-013 While rst_n=0 at an edge, the following SHALL all load 0, overriding stall and flush: wb_valid, reg_write, rd, write_data, instret.
REQ-014 Asserting reset mid-stall SHALL discard the held instruction without counting it.

Configuration
REQ-015 With WB_BYPASS_EN defined, the bypass ports SHALL exist and behave as follows:
- fwd_dataX = write_data when reg_write=1 and rd == dec_rsX.
- fwd_dataX = rf_dataX otherwise.
- dec_rsX = 0 always gives 0.
REQ-016 Without WB_BYPASS_EN, the dec_rs*, rf_data* and fwd_data* ports SHALL be absent and no bypass logic is generated.

Structure
REQ-017 The shared package riscv_pkg SHALL hold:
- the funct3 load-encoding constants;
- the XLEN=64 constant;
- the register-index width constant (5).
REQ-018 Load formatting SHALL live in a combinational sub-module load_formatter (inputs: funct3, addr_lo, raw data; output: 64-bit result).

Verification
REQ-019 A lb with in_mem_data=64'h0000_0000_0000_8000 and addr_lo=1 SHALL give write_data=64'hFFFF_FFFF_FFFF_FF80; the same access as lbu SHALL give 64'h80.
REQ-020 A lw with in_mem_data=64'h8765_4321_0000_0000 and addr_lo=4 SHALL give 64'hFFFF_FFFF_8765_4321; lwu SHALL give 64'h8765_4321.
REQ-021 An ALU write with in_rd=0 and in_alu_result=5 SHALL give wb_valid=1, reg_write=0 and instret+1.
REQ-022 With stall held 3 cycles and then flush=1: outputs SHALL stay frozen during the stall, instret SHALL not change, and the next cycle SHALL show wb_valid=0.
REQ-023 With instret preset near wrap via 2^64-1 retirements (forced), one more retirement SHALL give instret=0.
REQ-024 With WB_BYPASS_EN, rd=7, write_data=64'h1234, dec_rs1=7 and rf_data1=0: fwd_data1 SHALL be 64'h1234; with dec_rs1=0, fwd_data1 SHALL be 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Purpose : shared RV64 constants (XLEN, register index width, load funct3 codes) and the MEM/WB stage record.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

  localparam int XLEN      = 64;
  localparam int REG_IDX_W = 5;

  // Load encodings carried in funct3; 3'b111 is not a real load and is handled as ld.
  localparam logic [2:0] F3_LB     = 3'b000;
  localparam logic [2:0] F3_LH     = 3'b001;
  localparam logic [2:0] F3_LW     = 3'b010;
  localparam logic [2:0] F3_LD     = 3'b011;
  localparam logic [2:0] F3_LBU    = 3'b100;
  localparam logic [2:0] F3_LHU    = 3'b101;
  localparam logic [2:0] F3_LWU    = 3'b110;
  localparam logic [2:0] F3_LD_ALT = 3'b111;

  // Contents of the MEM/WB pipeline register.
  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      write_data;
  } wb_stage_t;

endpackage

// File: rtl/load_formatter.sv
// Purpose : extract and sign/zero-extend the addressed lane of a little-endian doubleword.
// Latency : combinational.
// Backpressure: none.
// Ports   : funct3 (load type), addr_lo (address bits [2:0]), raw (memory doubleword) -> result (64-bit).
module load_formatter
  import riscv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [2:0]      addr_lo,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] result
);

  logic [2:0]      lane;
  logic [XLEN-1:0] shifted;

  always_comb begin
    // Misaligned addresses are silently aligned down to the access size.
    case (funct3)
      F3_LH, F3_LHU:    lane = {addr_lo[2:1], 1'b0};
      F3_LW, F3_LWU:    lane = {addr_lo[2], 2'b00};
      F3_LD, F3_LD_ALT: lane = 3'b000;
      default:          lane = addr_lo;
    endcase

    shifted = raw >> {lane, 3'b000};

    case (funct3)
      F3_LB:   result = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      F3_LH:   result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LW:   result = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      F3_LBU:  result = {{(XLEN-8){1'b0}},         shifted[7:0]};
      F3_LHU:  result = {{(XLEN-16){1'b0}},        shifted[15:0]};
      F3_LWU:  result = {{(XLEN-32){1'b0}},        shifted[31:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Purpose : MEM/WB pipeline register with load formatting, x0 write suppression and retired-instruction counter.
// Latency : 1 cycle from in_* to reg_write/rd/write_data/wb_valid.
// Backpressure: stall holds the stage; flush (higher priority) loads a bubble; reset overrides both.
// Ports   : clk, rst_n (sync, active low), stall, flush, in_* (MEM-stage instruction),
//           reg_write/rd/write_data (register-file write), wb_valid, instret.
// Option  : WB_BYPASS_EN adds dec_rs1/2, rf_data1/2 inputs and fwd_data1/2 outputs (WB->decode bypass).
module mem_wb_stage
  import riscv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic                 in_reg_write,
  input  logic                 in_mem_to_reg,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic [2:0]           in_funct3,
  input  logic [2:0]           in_addr_lo,
  input  logic [XLEN-1:0]      in_alu_result,
  input  logic [XLEN-1:0]      in_mem_data,
`ifdef WB_BYPASS_EN
  input  logic [REG_IDX_W-1:0] dec_rs1,
  input  logic [REG_IDX_W-1:0] dec_rs2,
  input  logic [XLEN-1:0]      rf_data1,
  input  logic [XLEN-1:0]      rf_data2,
  output logic [XLEN-1:0]      fwd_data1,
  output logic [XLEN-1:0]      fwd_data2,
`endif
  output logic                 reg_write,
  output logic [REG_IDX_W-1:0] rd,
  output logic [XLEN-1:0]      write_data,
  output logic                 wb_valid,
  output logic [XLEN-1:0]      instret
);

  localparam logic [XLEN-1:0] ONE = XLEN'(1);

  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] instret_q;
  wb_stage_t       stage_d;
  wb_stage_t       stage_q;

  load_formatter u_load_formatter (
    .funct3  (in_funct3),
    .addr_lo (in_addr_lo),
    .raw     (in_mem_data),
    .result  (load_data)
  );

  // Formatting happens before the register so write_data leaves a flop directly.
  always_comb begin
    stage_d            = '0;
    stage_d.valid      = in_valid;
    stage_d.reg_write  = in_reg_write & in_valid & (in_rd != '0);
    stage_d.rd         = in_rd;
    stage_d.write_data = in_mem_to_reg ? load_data : in_alu_result;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q   <= '0;
      instret_q <= '0;
    end else begin
      // An instruction retires when it leaves WB; a flush on the same edge does not cancel that.
      if (stage_q.valid && !stall)
        instret_q <= instret_q + ONE;
      if (flush)
        stage_q <= '0;
      else if (!stall)
        stage_q <= stage_d;
    end
  end

  assign reg_write  = stage_q.reg_write;
  assign rd         = stage_q.rd;
  assign write_data = stage_q.write_data;
  assign wb_valid   = stage_q.valid;
  assign instret    = instret_q;

`ifdef WB_BYPASS_EN
  // reg_write is already 0 for rd==x0, but an x0 source must read 0 even if rf_data disagrees.
  always_comb begin
    if (dec_rs1 == '0)
      fwd_data1 = '0;
    else if (stage_q.reg_write && (stage_q.rd == dec_rs1))
      fwd_data1 = stage_q.write_data;
    else
      fwd_data1 = rf_data1;

    if (dec_rs2 == '0)
      fwd_data2 = '0;
    else if (stage_q.reg_write && (stage_q.rd == dec_rs2))
      fwd_data2 = stage_q.write_data;
    else
      fwd_data2 = rf_data2;
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Purpose : self-checking bench for mem_wb_stage (directed cases plus randomized traffic).
// Latency : n/a.
// Backpressure: n/a.
module tb_mem_wb_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, flush;
  logic        in_valid, in_reg_write, in_mem_to_reg;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3, in_addr_lo;
  logic [63:0] in_alu_result, in_mem_data;
  logic        reg_write, wb_valid;
  logic [4:0]  rd;
  logic [63:0] write_data, instret;
`ifdef WB_BYPASS_EN
  logic [4:0]  dec_rs1, dec_rs2;
  logic [63:0] rf_data1, rf_data2, fwd_data1, fwd_data2;
`endif

  mem_wb_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_reg_write  (in_reg_write),
    .in_mem_to_reg (in_mem_to_reg),
    .in_rd         (in_rd),
    .in_funct3     (in_funct3),
    .in_addr_lo    (in_addr_lo),
    .in_alu_result (in_alu_result),
    .in_mem_data   (in_mem_data),
`ifdef WB_BYPASS_EN
    .dec_rs1       (dec_rs1),
    .dec_rs2       (dec_rs2),
    .rf_data1      (rf_data1),
    .rf_data2      (rf_data2),
    .fwd_data1     (fwd_data1),
    .fwd_data2     (fwd_data2),
`endif
    .reg_write     (reg_write),
    .rd            (rd),
    .write_data    (write_data),
    .wb_valid      (wb_valid),
    .instret       (instret)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: what the WB stage should present after the last edge.
  logic        m_valid, m_rw;
  logic [4:0]  m_rd;
  logic [63:0] m_wd, m_instret;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-level load reference: pick `size` bytes at the aligned offset, then extend.
  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [2:0] addr,
                                           input logic [63:0] data);
    int size;
    bit sgn;
    int off;
    logic [63:0] val;
    case (f3)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: begin size = 4; sgn = 1'b1; end
      3'd4: begin size = 1; sgn = 1'b0; end
      3'd5: begin size = 2; sgn = 1'b0; end
      3'd6: begin size = 4; sgn = 1'b0; end
      default: begin size = 8; sgn = 1'b0; end
    endcase
    off = (int'(addr) / size) * size;
    val = '0;
    for (int i = 0; i < size; i++)
      val[i*8 +: 8] = data[(off+i)*8 +: 8];
    if (sgn && val[size*8-1])
      for (int i = size*8; i < 64; i++) val[i] = 1'b1;
    return val;
  endfunction

`ifdef WB_BYPASS_EN
  function automatic logic [63:0] ref_fwd(input logic [4:0] rs, input logic [63:0] rf);
    if (rs == 5'd0) return 64'd0;
    if (m_rw && m_rd == rs) return m_wd;
    return rf;
  endfunction
`endif

  // Apply the stage rules to the inputs present at the coming edge.
  task automatic model_edge();
    if (!rst_n) begin
      m_valid = 1'b0; m_rw = 1'b0; m_rd = '0; m_wd = '0; m_instret = '0;
    end else begin
      if (m_valid && !stall) m_instret = m_instret + 64'd1;
      if (flush) begin
        m_valid = 1'b0; m_rw = 1'b0; m_rd = '0; m_wd = '0;
      end else if (!stall) begin
        m_valid = in_valid;
        m_rw    = in_reg_write && in_valid && (in_rd != 5'd0);
        m_rd    = in_rd;
        m_wd    = in_mem_to_reg ? ref_load(in_funct3, in_addr_lo, in_mem_data) : in_alu_result;
      end
    end
  endtask

  task automatic check_all();
    check("wb_valid",   {63'd0, wb_valid},  {63'd0, m_valid});
    check("reg_write",  {63'd0, reg_write}, {63'd0, m_rw});
    check("rd",         {59'd0, rd},        {59'd0, m_rd});
    check("write_data", write_data,         m_wd);
    check("instret",    instret,            m_instret);
`ifdef WB_BYPASS_EN
    check("fwd_data1",  fwd_data1, ref_fwd(dec_rs1, rf_data1));
    check("fwd_data2",  fwd_data2, ref_fwd(dec_rs2, rf_data2));
`endif
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_ins(input logic v, input logic rw, input logic m2r, input logic [4:0] r,
                         input logic [2:0] f3, input logic [2:0] a, input logic [63:0] alu,
                         input logic [63:0] mem);
    in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r; in_rd = r;
    in_funct3 = f3; in_addr_lo = a; in_alu_result = alu; in_mem_data = mem;
  endtask

  task automatic rand_ins();
    logic [4:0] r;
    r = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
    set_ins($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), r, 3'($urandom), 3'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom});
`ifdef WB_BYPASS_EN
    case ($urandom_range(0, 3))
      0: dec_rs1 = 5'd0;
      1: dec_rs1 = m_rd;
      2: dec_rs1 = in_rd;
      default: dec_rs1 = 5'($urandom);
    endcase
    dec_rs2  = ($urandom_range(0, 1) == 0) ? m_rd : 5'($urandom);
    rf_data1 = {$urandom, $urandom};
    rf_data2 = {$urandom, $urandom};
`endif
  endtask

  logic [63:0] base;

  initial begin
    m_valid = 1'b0; m_rw = 1'b0; m_rd = '0; m_wd = '0; m_instret = '0;
    rst_n = 1'b0; stall = 1'b1; flush = 1'b1;
    set_ins(1'b1, 1'b1, 1'b0, 5'd3, 3'd0, 3'd0, 64'hDEAD, 64'hBEEF);
`ifdef WB_BYPASS_EN
    dec_rs1 = 5'd3; dec_rs2 = 5'd0; rf_data1 = 64'h11; rf_data2 = 64'h22;
`endif
    // Reset overrides stall and flush.
    tick();
    tick();
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;

    // lb / lbu at byte 1 of 0x8000.
    set_ins(1'b1, 1'b1, 1'b1, 5'd5, 3'b000, 3'd1, 64'h0, 64'h0000_0000_0000_8000);
    tick();
    check("lb_byte1", write_data, 64'hFFFF_FFFF_FFFF_FF80);
    set_ins(1'b1, 1'b1, 1'b1, 5'd5, 3'b100, 3'd1, 64'h0, 64'h0000_0000_0000_8000);
    tick();
    check("lbu_byte1", write_data, 64'h80);

    // lw / lwu at word 1.
    set_ins(1'b1, 1'b1, 1'b1, 5'd6, 3'b010, 3'd4, 64'h0, 64'h8765_4321_0000_0000);
    tick();
    check("lw_word1", write_data, 64'hFFFF_FFFF_8765_4321);
    set_ins(1'b1, 1'b1, 1'b1, 5'd6, 3'b110, 3'd4, 64'h0, 64'h8765_4321_0000_0000);
    tick();
    check("lwu_word1", write_data, 64'h8765_4321);

    // ALU write to x0: valid but no register write, and it retires.
    set_ins(1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 3'd0, 64'd5, 64'hFFFF);
    tick();
    check("x0_valid", {63'd0, wb_valid}, 64'd1);
    check("x0_no_write", {63'd0, reg_write}, 64'd0);
    base = instret;
    set_ins(1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 3'd0, 64'd0, 64'd0);
    tick();
    check("x0_retired", instret, base + 64'd1);

    // Stall three cycles with changing inputs, then flush.
    set_ins(1'b1, 1'b1, 1'b0, 5'd9, 3'd0, 3'd0, 64'hCAFE, 64'd0);
    tick();
    base = m_instret;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_ins();
      tick();
      check("stall_rd", {59'd0, rd}, 64'd9);
      check("stall_wd", write_data, 64'hCAFE);
      check("stall_instret", instret, base);
    end
    stall = 1'b0; flush = 1'b1;
    tick();
    check("flush_bubble", {63'd0, wb_valid}, 64'd0);
    check("flush_counts_retire", instret, base + 64'd1);
    flush = 1'b0;

`ifdef WB_BYPASS_EN
    set_ins(1'b1, 1'b1, 1'b0, 5'd7, 3'd0, 3'd0, 64'h1234, 64'd0);
    dec_rs1 = 5'd7; rf_data1 = 64'd0;
    tick();
    check("bypass_hit", fwd_data1, 64'h1234);
    dec_rs1 = 5'd0;
    #1;
    check("bypass_x0", fwd_data1, 64'd0);
`endif

    // Counter wrap: preload all-ones with a valid instruction in WB.
    set_ins(1'b1, 1'b0, 1'b0, 5'd1, 3'd0, 3'd0, 64'd1, 64'd0);
    tick();
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    check("wrap_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    check("wrap_zero", instret, 64'd0);

    // Reset while stalled discards the held instruction uncounted.
    set_ins(1'b1, 1'b1, 1'b0, 5'd4, 3'd0, 3'd0, 64'h77, 64'd0);
    tick();
    stall = 1'b1; rst_n = 1'b0;
    tick();
    check("rst_stall_valid", {63'd0, wb_valid}, 64'd0);
    check("rst_stall_instret", instret, 64'd0);
    stall = 1'b0; rst_n = 1'b1;

    // Randomized traffic with stalls, flushes and occasional resets.
    for (int i = 0; i < 400; i++) begin
      rand_ins();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 49) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
